// File: rtl/pcr_correct_calc_if.sv
// rtl/pcr_correct_calc_if.sv - TS byte stream tapped by the PCR correction block
interface pcr_correct_calc_if;
   logic       ts_sync;
   logic       ts_valid;
   logic [7:0] ts_data;

   modport master (output ts_sync, output ts_valid, output ts_data);
   modport slave  (input  ts_sync, input  ts_valid, input  ts_data);
endinterface

// File: rtl/pcr_correct_calc.sv
// rtl/pcr_correct_calc.sv - extracts PCR from TS packets and adds the path delay (27 MHz units)
// Optional: define PCR_DISC_CHK_EN to pass PCRs flagged with discontinuity uncorrected.
module pcr_correct_calc #(
   parameter int EXT_MOD = 300
) (
   input  logic                 clk,
   input  logic                 rst,
   pcr_correct_calc_if.slave    ts,
   input  logic                 cfg_corr_en,
   input  logic                 cfg_pid_en,
   input  logic [12:0]          cfg_pid,
   input  logic [32:0]          cfg_dly_base,
   input  logic [8:0]           cfg_dly_ext,
   output logic [41:0]          pcr_correct_data,
   output logic                 pcr_correct_ac_ena,
   output logic                 pcr_err
);

   logic [7:0]  idx;
   logic [12:0] pid;
   logic [1:0]  afc;
   logic [7:0]  af_len;
   logic        pcr_flag;
   logic [31:0] base_hi;
   logic        base_lo;
   logic        ext_hi;
`ifdef PCR_DISC_CHK_EN
   logic        disc;
   logic        disc1;
`endif

   logic        v1;
   logic [32:0] base1;
   logic [8:0]  ext1;
   logic        carry1;
   logic        bad1;
   logic [12:0] pid1;

   logic        pcr_pkt;
   logic [8:0]  ext_in;
   logic [8:0]  dly_ext_sat;
   logic [9:0]  s_ext;
   logic        carry;
   logic [8:0]  ext_adj;
   logic        rej;

   always_comb begin
      pcr_pkt     = afc[1] && (af_len != 8'd0) && pcr_flag;
      ext_in      = {ext_hi, ts.ts_data};
      dly_ext_sat = (cfg_dly_ext >= 9'(EXT_MOD)) ? 9'(EXT_MOD - 1) : cfg_dly_ext;
      s_ext       = {1'b0, ext_in} + {1'b0, dly_ext_sat};
      carry       = (s_ext >= 10'(EXT_MOD));
      ext_adj     = carry ? 9'(s_ext - 10'(EXT_MOD)) : s_ext[8:0];
      rej         = !cfg_corr_en || (cfg_pid_en && (pid1 != cfg_pid));
`ifdef PCR_DISC_CHK_EN
      rej         = rej || disc1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx                <= 8'd0;
         pid                <= 13'd0;
         afc                <= 2'd0;
         af_len             <= 8'd0;
         pcr_flag           <= 1'b0;
         base_hi            <= 32'd0;
         base_lo            <= 1'b0;
         ext_hi             <= 1'b0;
`ifdef PCR_DISC_CHK_EN
         disc               <= 1'b0;
         disc1              <= 1'b0;
`endif
         v1                 <= 1'b0;
         base1              <= 33'd0;
         ext1               <= 9'd0;
         carry1             <= 1'b0;
         bad1               <= 1'b0;
         pid1               <= 13'd0;
         pcr_correct_data   <= 42'd0;
         pcr_correct_ac_ena <= 1'b0;
         pcr_err            <= 1'b0;
      end else begin
         pcr_err <= 1'b0;
         v1      <= 1'b0;
         if (ts.ts_valid) begin
            if (ts.ts_sync) begin
               // A sync inside the PCR field means the previous packet was cut short.
               if (idx >= 8'd6 && idx <= 8'd11 && pcr_pkt)
                  pcr_err <= 1'b1;
               idx      <= 8'd1;
               afc      <= 2'd0;
               af_len   <= 8'd0;
               pcr_flag <= 1'b0;
            end else if (idx != 8'd0) begin
               idx <= (idx == 8'd187) ? 8'd0 : idx + 8'd1;
               case (idx)
                  8'd1: pid[12:8] <= ts.ts_data[4:0];
                  8'd2: pid[7:0]  <= ts.ts_data;
                  8'd3: afc       <= ts.ts_data[5:4];
                  8'd4: af_len    <= ts.ts_data;
                  8'd5: begin
                     pcr_flag <= ts.ts_data[4];
`ifdef PCR_DISC_CHK_EN
                     disc     <= ts.ts_data[7];
`endif
                  end
                  8'd6, 8'd7, 8'd8, 8'd9: base_hi <= {base_hi[23:0], ts.ts_data};
                  8'd10: begin
                     base_lo <= ts.ts_data[7];
                     ext_hi  <= ts.ts_data[0];
                  end
                  8'd11: if (pcr_pkt) begin
                     v1     <= 1'b1;
                     base1  <= {base_hi, base_lo};
                     ext1   <= ext_adj;
                     carry1 <= carry;
                     bad1   <= (ext_in >= 9'(EXT_MOD));
                     pid1   <= pid;
`ifdef PCR_DISC_CHK_EN
                     disc1  <= disc;
`endif
                  end
                  default: ;
               endcase
            end
         end
         // Second stage runs on the clock, independent of ts_valid gaps.
         if (v1) begin
            if (bad1) begin
               pcr_correct_ac_ena <= 1'b0;
               pcr_err            <= 1'b1;
            end else if (rej) begin
               pcr_correct_ac_ena <= 1'b0;
            end else begin
               pcr_correct_data   <= {base1 + cfg_dly_base + 33'(carry1), ext1};
               pcr_correct_ac_ena <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pcr_correct_calc.sv
// tb/tb_pcr_correct_calc.sv - table, corner-case and randomized checks of pcr_correct_calc
module tb_pcr_correct_calc;

   typedef struct {
      logic [12:0] pid;
      logic [1:0]  afc;
      logic [7:0]  aflen;
      logic        flag;
      logic        disc;
      logic [32:0] base;
      logic [8:0]  ext;
      logic [32:0] dbase;
      logic [8:0]  dext;
      logic        corr_en;
      logic        pid_en;
      logic [12:0] cfg_pid;
      logic [41:0] exp_data;
      logic        exp_ac;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_corr_en;
   logic        cfg_pid_en;
   logic [12:0] cfg_pid;
   logic [32:0] cfg_dly_base;
   logic [8:0]  cfg_dly_ext;
   logic [41:0] pcr_correct_data;
   logic        pcr_correct_ac_ena;
   logic        pcr_err;

   int checks = 0;
   int failures = 0;
   logic [41:0] m_data;
   logic        m_ac;

   pcr_correct_calc_if tsif ();

   pcr_correct_calc dut (
      .clk                (clk),
      .rst                (rst),
      .ts                 (tsif),
      .cfg_corr_en        (cfg_corr_en),
      .cfg_pid_en         (cfg_pid_en),
      .cfg_pid            (cfg_pid),
      .cfg_dly_base       (cfg_dly_base),
      .cfg_dly_ext        (cfg_dly_ext),
      .pcr_correct_data   (pcr_correct_data),
      .pcr_correct_ac_ena (pcr_correct_ac_ena),
      .pcr_err            (pcr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: PCR as a single 27 MHz tick count, delay added, then split back.
   task automatic model(input vec_t v, input logic [41:0] pd, input logic pa,
                        output logic [41:0] nd, output logic na, output logic ne);
      longint unsigned tot;
      longint unsigned dx;
      logic            disc_rej;
      nd = pd; na = pa; ne = 1'b0;
`ifdef PCR_DISC_CHK_EN
      disc_rej = v.disc;
`else
      disc_rej = 1'b0;
`endif
      if (v.afc[1] && v.aflen != 8'd0 && v.flag) begin
         if (v.ext >= 9'd300) begin
            na = 1'b0; ne = 1'b1;
         end else if (!v.corr_en || (v.pid_en && v.pid != v.cfg_pid) || disc_rej) begin
            na = 1'b0;
         end else begin
            dx  = (v.dext >= 9'd300) ? 64'd299 : 64'(v.dext);
            tot = 64'(v.base) * 300 + 64'(v.ext) + 64'(v.dbase) * 300 + dx;
            nd  = {33'(tot / 300), 9'(tot % 300)};
            na  = 1'b1;
         end
      end
   endtask

   function automatic vec_t mk(input logic [12:0] pid, input logic [1:0] afc, input logic [7:0] aflen,
                               input logic flag, input logic disc, input logic [32:0] base,
                               input logic [8:0] ext, input logic [32:0] dbase, input logic [8:0] dext,
                               input logic corr_en, input logic pid_en, input logic [12:0] cfg_pid_v,
                               input logic [41:0] edata, input logic eac, input logic eerr);
      vec_t v;
      v.pid = pid; v.afc = afc; v.aflen = aflen; v.flag = flag; v.disc = disc;
      v.base = base; v.ext = ext; v.dbase = dbase; v.dext = dext;
      v.corr_en = corr_en; v.pid_en = pid_en; v.cfg_pid = cfg_pid_v;
      v.exp_data = edata; v.exp_ac = eac; v.exp_err = eerr;
      return v;
   endfunction

   task automatic put_byte(input logic s, input logic [7:0] d);
      tsif.ts_valid = 1'b1;
      tsif.ts_sync  = s;
      tsif.ts_data  = d;
      @(posedge clk);
      #1;
      tsif.ts_valid = 1'b0;
      tsif.ts_sync  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         tsif.ts_valid = 1'b0;
         tsif.ts_sync  = 1'($urandom);
         tsif.ts_data  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      tsif.ts_sync = 1'b0;
   endtask

   // Sends the first nb bytes of a packet; checks the T+1..T+3 window after byte 11.
   task automatic send_pkt(input vec_t v, input int nb, input bit gaps,
                           input logic exp_sync_err, input bit rst_t1);
      logic [7:0] b [188];
      b[0]  = 8'h47;
      b[1]  = {3'($urandom), v.pid[12:8]};
      b[2]  = v.pid[7:0];
      b[3]  = {2'($urandom), v.afc, 4'($urandom)};
      b[4]  = v.aflen;
      b[5]  = {v.disc, 2'($urandom), v.flag, 4'($urandom)};
      b[6]  = v.base[32:25];
      b[7]  = v.base[24:17];
      b[8]  = v.base[16:9];
      b[9]  = v.base[8:1];
      b[10] = {v.base[0], 6'($urandom), v.ext[8]};
      b[11] = v.ext[7:0];
      for (int i = 12; i < 188; i++) b[i] = 8'($urandom);
      cfg_corr_en  = v.corr_en;
      cfg_pid_en   = v.pid_en;
      cfg_pid      = v.cfg_pid;
      cfg_dly_base = v.dbase;
      cfg_dly_ext  = v.dext;
      for (int i = 0; i < nb; i++) begin
         if (gaps && $urandom_range(3) == 0) idle(int'($urandom_range(2, 1)));
         put_byte(i == 0, b[i]);
         if (i == 0) chk("sync_err", 64'(pcr_err), 64'(exp_sync_err));
         if (i == 11 && rst_t1) begin
            rst = 1'b1;
            #1;
            chk("rst_data", 64'(pcr_correct_data), 64'd0);
            chk("rst_ac", 64'(pcr_correct_ac_ena), 64'd0);
            chk("rst_err", 64'(pcr_err), 64'd0);
            idle(2);
            rst = 1'b0;
            idle(3);
            chk("post_rst_data", 64'(pcr_correct_data), 64'd0);
            chk("post_rst_ac", 64'(pcr_correct_ac_ena), 64'd0);
            m_data = 42'd0;
            m_ac   = 1'b0;
            return;
         end
         if (i == 11) begin
            chk("t1_data", 64'(pcr_correct_data), 64'(m_data));
            chk("t1_ac", 64'(pcr_correct_ac_ena), 64'(m_ac));
            chk("t1_err", 64'(pcr_err), 64'd0);
            idle(1);
            chk("t2_data", 64'(pcr_correct_data), 64'(v.exp_data));
            chk("t2_ac", 64'(pcr_correct_ac_ena), 64'(v.exp_ac));
            chk("t2_err", 64'(pcr_err), 64'(v.exp_err));
            idle(1);
            chk("t3_err", 64'(pcr_err), 64'd0);
            m_data = v.exp_data;
            m_ac   = v.exp_ac;
         end
      end
   endtask

   vec_t tv [12];

   initial begin
      vec_t        v;
      logic [41:0] nd;
      logic        na;
      logic        ne;

      tv[0]  = mk(13'h100, 2'b11, 8'd7, 1, 0, 33'h1000, 9'd100, 33'd5, 9'd250, 1, 0, 13'h100,
                  {33'h1006, 9'd50}, 1, 0);
      tv[1]  = mk(13'h101, 2'b11, 8'd7, 1, 0, 33'h5, 9'd5, 33'd0, 9'd0, 1, 1, 13'h100,
                  {33'h1006, 9'd50}, 0, 0);
      tv[2]  = mk(13'h100, 2'b11, 8'd7, 1, 0, 33'h2000, 9'd0, 33'd1, 9'd1, 1, 1, 13'h100,
                  {33'h2001, 9'd1}, 1, 0);
      tv[3]  = mk(13'h100, 2'b11, 8'd7, 1, 0, 33'h77, 9'h1FF, 33'd0, 9'd0, 1, 0, 13'h100,
                  {33'h2001, 9'd1}, 0, 1);
      tv[4]  = mk(13'h100, 2'b11, 8'd7, 1, 0, 33'h1_FFFF_FFFF, 9'd299, 33'd0, 9'd1, 1, 0, 13'h100,
                  42'd0, 1, 0);
      tv[5]  = mk(13'h100, 2'b10, 8'd7, 1, 0, 33'h10, 9'd10, 33'd0, 9'd400, 1, 0, 13'h100,
                  {33'h11, 9'd9}, 1, 0);
      tv[6]  = mk(13'h100, 2'b11, 8'd7, 1, 0, 33'h123, 9'd1, 33'd0, 9'd0, 0, 0, 13'h100,
                  {33'h11, 9'd9}, 0, 0);
      tv[7]  = mk(13'h100, 2'b11, 8'd7, 0, 0, 33'h55, 9'd2, 33'd0, 9'd0, 1, 0, 13'h100,
                  {33'h11, 9'd9}, 0, 0);
      tv[8]  = mk(13'h100, 2'b01, 8'd7, 1, 0, 33'h56, 9'd3, 33'd0, 9'd0, 1, 0, 13'h100,
                  {33'h11, 9'd9}, 0, 0);
      tv[9]  = mk(13'h100, 2'b11, 8'd0, 1, 0, 33'h57, 9'd4, 33'd0, 9'd0, 1, 0, 13'h100,
                  {33'h11, 9'd9}, 0, 0);
      tv[10] = mk(13'h100, 2'b11, 8'd7, 1, 0, 33'h58, 9'd300, 33'd0, 9'd0, 1, 0, 13'h100,
                  {33'h11, 9'd9}, 0, 1);
`ifdef PCR_DISC_CHK_EN
      tv[11] = mk(13'h100, 2'b11, 8'd7, 1, 1, 33'h1000, 9'd100, 33'd5, 9'd250, 1, 0, 13'h100,
                  {33'h11, 9'd9}, 0, 0);
`else
      tv[11] = mk(13'h100, 2'b11, 8'd7, 1, 1, 33'h1000, 9'd100, 33'd5, 9'd250, 1, 0, 13'h100,
                  {33'h1006, 9'd50}, 1, 0);
`endif

      rst = 1'b1;
      tsif.ts_valid = 1'b0; tsif.ts_sync = 1'b0; tsif.ts_data = 8'd0;
      cfg_corr_en = 1'b0; cfg_pid_en = 1'b0; cfg_pid = 13'd0;
      cfg_dly_base = 33'd0; cfg_dly_ext = 9'd0;
      m_data = 42'd0; m_ac = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", 64'(pcr_correct_data), 64'd0);
      chk("reset_ac", 64'(pcr_correct_ac_ena), 64'd0);
      chk("reset_err", 64'(pcr_err), 64'd0);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 12; i++) send_pkt(tv[i], 188, (i % 2) == 1, 1'b0, 1'b0);

      // Sync at idx 8 of a PCR packet: error pulse, then the next packet updates.
      send_pkt(tv[0], 8, 1'b0, 1'b0, 1'b0);
      v = tv[2];
      model(v, m_data, m_ac, nd, na, ne);
      v.exp_data = nd; v.exp_ac = na; v.exp_err = ne;
      send_pkt(v, 188, 1'b0, 1'b1, 1'b0);
      // Sync at idx 3 is before the PCR flag: silent abort.
      send_pkt(tv[4], 3, 1'b0, 1'b0, 1'b0);
      v = tv[0];
      model(v, m_data, m_ac, nd, na, ne);
      v.exp_data = nd; v.exp_ac = na; v.exp_err = ne;
      send_pkt(v, 188, 1'b1, 1'b0, 1'b0);
      // Async reset while the PCR sits in the first pipeline stage.
      send_pkt(tv[5], 12, 1'b0, 1'b0, 1'b1);
      idle(1);
      v = tv[5];
      model(v, m_data, m_ac, nd, na, ne);
      v.exp_data = nd; v.exp_ac = na; v.exp_err = ne;
      send_pkt(v, 188, 1'b0, 1'b0, 1'b0);

      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(2))
            0:       v.pid = 13'h100;
            1:       v.pid = 13'h101;
            default: v.pid = 13'($urandom);
         endcase
         v.afc     = 2'($urandom);
         v.aflen   = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
         v.flag    = ($urandom_range(3) != 0);
         v.disc    = 1'($urandom);
         v.base    = {1'($urandom), 32'($urandom)};
         v.ext     = ($urandom_range(7) == 0) ? 9'($urandom_range(511, 300)) : 9'($urandom_range(299));
         v.dbase   = {1'($urandom), 32'($urandom)};
         v.dext    = ($urandom_range(5) == 0) ? 9'($urandom_range(511, 300)) : 9'($urandom_range(299));
         v.corr_en = ($urandom_range(7) != 0);
         v.pid_en  = 1'($urandom);
         v.cfg_pid = 13'h100;
         model(v, m_data, m_ac, nd, na, ne);
         v.exp_data = nd; v.exp_ac = na; v.exp_err = ne;
         send_pkt(v, 188, 1'b1, 1'b0, 1'b0);
      end

      idle(4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
